// File: rtl/fft16_dif_stage.sv
// Purpose: first radix-2 DIF stage of a streaming 16-point FFT (single-path delay feedback).
// Latency: sums 1 cycle after input index 8..15; twiddled differences follow in the next 8 cycles.
// Backpressure: none; one sample per cycle, back-to-back frames stream with no idle cycles.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   start16, end16           input frame markers (end16 unused; the index counter is authoritative)
//   A_real, A_img            input complex sample, DW-bit signed
//   out_real_16, out_img_16  output complex sample, registered, 0 when not valid
//   start8, end8             first/last sample of each 8-sample output half-frame
module fft16_dif_stage #(
  parameter int DW = 32,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start16,
  input  logic          end16,
  input  logic [DW-1:0] A_real,
  input  logic [DW-1:0] A_img,
  output logic [DW-1:0] out_real_16,
  output logic [DW-1:0] out_img_16,
  output logic          start8,
  output logic          end8
);

  localparam int PW = DW + TW + 1;

  logic          unused_end16;
  assign unused_end16 = end16;

  // Input index counter: idx_q holds the index the next sample will carry.
  logic [3:0]    idx_q;
  logic          run_q;
  // Drain of the twiddled differences after a frame's last butterfly.
  logic [2:0]    didx_q;
  logic          drn_q;
  // 8-entry complex delay line.
  logic [DW-1:0] dly_re [8];
  logic [DW-1:0] dly_im [8];

  logic          cur_vld;
  logic [3:0]    cur_idx;
  logic [2:0]    slot;
  logic [DW-1:0] b_re, b_im;
  logic [DW-1:0] sum_re, sum_im;
  logic [DW-1:0] dif_re, dif_im;
  logic [DW-1:0] tw_re, tw_im;
  logic signed [TW-1:0] cos_w, sin_w;
  logic signed [PW-1:0] dre, dim, ce, se, pre, pim;

  // W16^n = c - j*s, Q1.14
  always_comb begin
    cos_w = 16'sd0;
    sin_w = 16'sd0;
    case (slot)
      3'd0: begin cos_w =  16'sd16384; sin_w = 16'sd0;     end
      3'd1: begin cos_w =  16'sd15137; sin_w = 16'sd6270;  end
      3'd2: begin cos_w =  16'sd11585; sin_w = 16'sd11585; end
      3'd3: begin cos_w =  16'sd6270;  sin_w = 16'sd15137; end
      3'd4: begin cos_w =  16'sd0;     sin_w = 16'sd16384; end
      3'd5: begin cos_w = -16'sd6270;  sin_w = 16'sd15137; end
      3'd6: begin cos_w = -16'sd11585; sin_w = 16'sd11585; end
      default: begin cos_w = -16'sd15137; sin_w = 16'sd6270; end
    endcase
  end

  always_comb begin
    // start16 overrides the counter, which also aborts any frame in progress.
    cur_vld = start16 | run_q;
    cur_idx = start16 ? 4'd0 : idx_q;
    slot    = cur_idx[2:0];
    b_re    = dly_re[slot];
    b_im    = dly_im[slot];
    sum_re  = b_re + A_real;
    sum_im  = b_im + A_img;
    dif_re  = b_re - A_real;
    dif_im  = b_im - A_img;
    dre     = PW'($signed(dif_re));
    dim     = PW'($signed(dif_im));
    ce      = PW'(cos_w);
    se      = PW'(sin_w);
    // (dr + j di)(c - j s), round half up before dropping 14 fraction bits
    pre     = dre * ce + dim * se + PW'(8192);
    pim     = dim * ce - dre * se + PW'(8192);
    tw_re   = DW'(pre >>> 14);
    tw_im   = DW'(pim >>> 14);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      run_q       <= 1'b0;
      didx_q      <= '0;
      drn_q       <= 1'b0;
      out_real_16 <= '0;
      out_img_16  <= '0;
      start8      <= 1'b0;
      end8        <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        dly_re[i] <= '0;
        dly_im[i] <= '0;
      end
    end else begin
      if (cur_vld) idx_q <= cur_idx + 4'd1;
      run_q <= cur_vld && (cur_idx != 4'd15);

      if (cur_vld && cur_idx == 4'd15) begin
        drn_q  <= 1'b1;
        didx_q <= '0;
      end else if (drn_q) begin
        didx_q <= didx_q + 3'd1;
        if (didx_q == 3'd7) drn_q <= 1'b0;
      end

      out_real_16 <= '0;
      out_img_16  <= '0;
      start8      <= 1'b0;
      end8        <= 1'b0;

      // Drain reads the slot before a concurrently filling frame overwrites it.
      if (drn_q) begin
        out_real_16 <= dly_re[didx_q];
        out_img_16  <= dly_im[didx_q];
        start8      <= (didx_q == 3'd0);
        end8        <= (didx_q == 3'd7);
      end

      if (cur_vld) begin
        if (!cur_idx[3]) begin
          dly_re[slot] <= A_real;
          dly_im[slot] <= A_img;
        end else begin
          out_real_16  <= sum_re;
          out_img_16   <= sum_im;
          start8       <= (slot == 3'd0);
          end8         <= (slot == 3'd7);
          dly_re[slot] <= tw_re;
          dly_im[slot] <= tw_im;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft16_dif_stage.sv
// Directed-vector bench for fft16_dif_stage: a cycle-indexed stimulus table and a
// hand-computed expected-output table, compared every cycle 1ns after the clock edge.
module tb_fft16_dif_stage;

  localparam int N     = 140;
  localparam int RST_T = 105;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, end16;
  logic [31:0] A_real, A_img;
  logic [31:0] out_real_16, out_img_16;
  logic        start8, end8;

  fft16_dif_stage #(.DW(32), .TW(16)) dut (
    .clk(clk), .rst(rst), .start16(start16), .end16(end16),
    .A_real(A_real), .A_img(A_img),
    .out_real_16(out_real_16), .out_img_16(out_img_16),
    .start8(start8), .end8(end8)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  bit st [N];
  bit en [N];
  int xr [N];
  int er [N];
  int ei [N];
  bit es [N];
  bit ee [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // kinds: 0 impulse x[0]=1000, 1 constant 100, 2 x[8]=1000, 3 x[1]=16384
  function automatic int in_val(int kind, int k);
    case (kind)
      0: return (k == 0) ? 1000 : 0;
      1: return 100;
      2: return (k == 8) ? 1000 : 0;
      default: return (k == 1) ? 16384 : 0;
    endcase
  endfunction

  function automatic int sum_val(int kind, int k);
    case (kind)
      0: return (k == 0) ? 1000 : 0;
      1: return 200;
      2: return (k == 0) ? 1000 : 0;
      default: return (k == 1) ? 16384 : 0;
    endcase
  endfunction

  function automatic int dif_re(int kind, int k);
    case (kind)
      0: return (k == 0) ? 1000 : 0;
      1: return 0;
      2: return (k == 0) ? -1000 : 0;
      default: return (k == 1) ? 15137 : 0;
    endcase
  endfunction

  function automatic int dif_im(int kind, int k);
    return (kind == 3 && k == 1) ? -6270 : 0;
  endfunction

  task automatic put_frame(int base, int kind, int len, int nsum, bit diffs);
    for (int k = 0; k < len; k++) begin
      st[base+k] = (k == 0);
      en[base+k] = (k == 15);
      xr[base+k] = in_val(kind, k);
    end
    for (int k = 0; k < 8; k++) begin
      if (k < nsum) begin
        er[base+8+k] = sum_val(kind, k);
        ei[base+8+k] = 0;
        es[base+8+k] = (k == 0);
        ee[base+8+k] = (k == 7);
      end
      if (diffs) begin
        er[base+16+k] = dif_re(kind, k);
        ei[base+16+k] = dif_im(kind, k);
        es[base+16+k] = (k == 0);
        ee[base+16+k] = (k == 7);
      end
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_dat"}, {out_real_16, out_img_16}, 64'd0);
    check({tag, "_flg"}, {62'd0, start8, end8}, 64'd0);
  endtask

  initial begin
    for (int t = 0; t < N; t++) begin
      st[t] = 0; en[t] = 0; xr[t] = 0;
      er[t] = 0; ei[t] = 0; es[t] = 0; ee[t] = 0;
    end
    put_frame(2,  0, 16, 8, 1);   // impulse
    put_frame(18, 1, 16, 8, 1);   // constant, back-to-back
    put_frame(34, 2, 16, 8, 1);   // x[8] only
    put_frame(50, 3, 16, 8, 1);   // x[1] only, twiddle W16^1
    put_frame(66, 1, 11, 3, 0);   // aborted at index 11: 3 sums, no end8, no diffs
    put_frame(77, 0, 16, 8, 1);   // restart frame
    put_frame(93, 3, 16, 8, 0);   // cut by reset at RST_T
    for (int t = RST_T + 1; t < 110; t++) begin
      er[t] = 0; ei[t] = 0; es[t] = 0; ee[t] = 0;
    end
    put_frame(110, 1, 16, 8, 1);  // recovery after reset

    rst = 1'b1; start16 = 1'b0; end16 = 1'b0; A_real = '0; A_img = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    for (int t = 0; t < N; t++) begin
      start16 = st[t];
      end16   = en[t];
      A_real  = 32'(xr[t]);
      A_img   = '0;
      @(posedge clk);
      #1;
      check($sformatf("dat@%0d", t), {out_real_16, out_img_16}, {32'(er[t]), 32'(ei[t])});
      check($sformatf("flg@%0d", t), {62'd0, start8, end8}, {62'd0, es[t], ee[t]});
      if (t == RST_T) begin
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
      end
      if (t == RST_T + 2) rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
